// File: rtl/display_file_bus_arbiter_pkg.sv
// Shared types, widths and the arbitration rule for the display file bus arbiter.
package display_bus_pkg;

    localparam int DEFAULT_BURST_LEN = 4;
    localparam int ADDR_W            = 22;
    localparam int DATA_W            = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        BURST   = 2'd2
    } arb_state_t;

    // Returns the index of the requester that gets the next grant.
    // Under contention, round-robin hands the bus to whoever did not win last;
    // fixed priority always favours requester 0.
    function automatic logic rr_pick(input logic req0,
                                     input logic req1,
                                     input logic last_grant,
                                     input logic round_robin);
        logic win;
        if (req0 && req1) begin
            win = round_robin ? ~last_grant : 1'b0;
        end else begin
            win = req1;
        end
        return win;
    endfunction

endpackage

// File: rtl/display_file_bus_arbiter_if.sv
// Bundle of the decoder-side and memory-side handshake signals around the arbiter.
// The master view belongs to the arbiter (it masters the memory request port);
// the slave view is the surrounding decoders plus memory controller.
// mem_din is broadcast straight from memory to both decoders and never passes the arbiter.
interface display_file_bus_arbiter_if;
    import display_bus_pkg::*;

    logic [ADDR_W-1:0] req0_address;
    logic              req0_as;
    logic              req0_bus_ack;
    logic              req0_burstdata_valid;
    logic [ADDR_W-1:0] req1_address;
    logic              req1_as;
    logic              req1_bus_ack;
    logic              req1_burstdata_valid;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_as;
    logic              mem_ack;
    logic              mem_burstdata_valid;
    logic [DATA_W-1:0] mem_din;
    logic              owner;
    logic              busy;

    modport master (
        input  req0_address, req0_as, req1_address, req1_as,
               mem_ack, mem_burstdata_valid,
        output req0_bus_ack, req0_burstdata_valid,
               req1_bus_ack, req1_burstdata_valid,
               mem_address, mem_as, owner, busy
    );

    modport slave (
        output req0_address, req0_as, req1_address, req1_as,
               mem_ack, mem_burstdata_valid, mem_din,
        input  req0_bus_ack, req0_burstdata_valid,
               req1_bus_ack, req1_burstdata_valid,
               mem_address, mem_as, owner, busy
    );

endinterface

// File: rtl/display_file_bus_arbiter.sv
// Shares one video-memory burst port between the two display file decoders.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | no grant outstanding; picks a winner when any request is up
//  REQUEST | mem_as held with the winner's address, waiting for mem_ack
//  BURST   | request accepted; steering beats to the owner until the last
module display_file_bus_arbiter
    import display_bus_pkg::*;
#(
    parameter int BURST_LEN   = DEFAULT_BURST_LEN,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    display_file_bus_arbiter_if.master   bus
);

    localparam int               CNT_W     = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_t        state_q;
    logic              mem_as_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic              owner_q;
    logic              last_grant_q;
    logic [CNT_W-1:0]  beat_cnt_q;

    logic win;
    logic owner_req;
    logic ack_phase;
    logic beat_phase;

    assign win       = rr_pick(bus.req0_as, bus.req1_as, last_grant_q, ROUND_ROBIN);
    assign owner_req = owner_q ? bus.req1_as : bus.req0_as;

    // A beat coinciding with mem_ack is the first beat of the burst, so steering
    // is open both in BURST and on the accepting REQUEST cycle.
    assign ack_phase  = (state_q == REQUEST) && bus.mem_ack;
    assign beat_phase = ((state_q == BURST) || ack_phase) && bus.mem_burstdata_valid;

    assign bus.req0_bus_ack         = ack_phase  && !owner_q;
    assign bus.req1_bus_ack         = ack_phase  &&  owner_q;
    assign bus.req0_burstdata_valid = beat_phase && !owner_q;
    assign bus.req1_burstdata_valid = beat_phase &&  owner_q;
    assign bus.mem_as               = mem_as_q;
    assign bus.mem_address          = mem_address_q;
    assign bus.owner                = owner_q;
    assign bus.busy                 = (state_q != IDLE);

    // Arbitration FSM with its registered memory request, owner and beat counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            mem_as_q      <= 1'b0;
            mem_address_q <= '0;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            beat_cnt_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req0_as || bus.req1_as) begin
                        owner_q       <= win;
                        mem_address_q <= win ? bus.req1_address : bus.req0_address;
                        mem_as_q      <= 1'b1;
                        state_q       <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (bus.mem_ack) begin
                        mem_as_q     <= 1'b0;
                        last_grant_q <= owner_q;
                        if (bus.mem_burstdata_valid && (LAST_BEAT == '0)) begin
                            beat_cnt_q <= '0;
                            state_q    <= IDLE;
                        end else begin
                            beat_cnt_q <= {{(CNT_W-1){1'b0}}, bus.mem_burstdata_valid};
                            state_q    <= BURST;
                        end
                    end else if (!owner_req) begin
                        // Decoder withdrew (reload) before memory accepted: the grant
                        // is abandoned and does not count for round-robin fairness.
                        mem_as_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                BURST: begin
                    if (bus.mem_burstdata_valid) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_q <= '0;
                            state_q    <= IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    mem_as_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_file_bus_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share one stimulus
// stream; a reference model predicts grants and beat steering into scoreboard queues.
`timescale 1ns/1ps
module tb_display_file_bus_arbiter;
    import display_bus_pkg::*;

    localparam int BL = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [21:0] a0 = '0, a1 = '0;
    logic        r0 = 1'b0, r1 = 1'b0, m_ack = 1'b0, m_bv = 1'b0;
    logic [15:0] m_din = '0;

    display_file_bus_arbiter_if bus_rr ();
    display_file_bus_arbiter_if bus_fp ();

    display_file_bus_arbiter #(.BURST_LEN(BL), .ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .reset_n(reset_n), .bus(bus_rr));
    display_file_bus_arbiter #(.BURST_LEN(BL), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .reset_n(reset_n), .bus(bus_fp));

    assign bus_rr.req0_address = a0;  assign bus_fp.req0_address = a0;
    assign bus_rr.req1_address = a1;  assign bus_fp.req1_address = a1;
    assign bus_rr.req0_as = r0;       assign bus_fp.req0_as = r0;
    assign bus_rr.req1_as = r1;       assign bus_fp.req1_as = r1;
    assign bus_rr.mem_ack = m_ack;    assign bus_fp.mem_ack = m_ack;
    assign bus_rr.mem_burstdata_valid = m_bv; assign bus_fp.mem_burstdata_valid = m_bv;
    assign bus_rr.mem_din = m_din;    assign bus_fp.mem_din = m_din;

    // index 0 = round-robin DUT, index 1 = fixed-priority DUT
    logic        o_as   [2];
    logic [21:0] o_addr [2];
    logic        o_own  [2];
    logic        o_busy [2];
    logic [1:0]  o_ack  [2];
    logic [1:0]  o_bv   [2];
    assign o_as[0] = bus_rr.mem_as;        assign o_as[1] = bus_fp.mem_as;
    assign o_addr[0] = bus_rr.mem_address; assign o_addr[1] = bus_fp.mem_address;
    assign o_own[0] = bus_rr.owner;        assign o_own[1] = bus_fp.owner;
    assign o_busy[0] = bus_rr.busy;        assign o_busy[1] = bus_fp.busy;
    assign o_ack[0] = {bus_rr.req1_bus_ack, bus_rr.req0_bus_ack};
    assign o_ack[1] = {bus_fp.req1_bus_ack, bus_fp.req0_bus_ack};
    assign o_bv[0] = {bus_rr.req1_burstdata_valid, bus_rr.req0_burstdata_valid};
    assign o_bv[1] = {bus_fp.req1_burstdata_valid, bus_fp.req0_burstdata_valid};

    typedef struct packed {
        logic        owner;
        logic [21:0] addr;
    } grant_t;

    int     n_cmp  = 0;
    int     n_fail = 0;
    grant_t gq0[$], gq1[$];
    logic   bq0[$], bq1[$];
    logic   mdl_last [2] = '{1'b1, 1'b1};
    logic   cur_own  [2] = '{1'b0, 1'b0};
    logic   prev_as  [2] = '{1'b0, 1'b0};
    logic   prev_ack = 1'b0;
    grant_t mon_g;
    logic   mon_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Reference arbitration: a lone requester wins; under contention the
    // round-robin arbiter favours whoever did not win last, fixed favours 0.
    function automatic logic pick_model(input int k, input logic q0, input logic q1);
        if (q0 && !q1) return 1'b0;
        if (q1 && !q0) return 1'b1;
        return (k == 0) ? !mdl_last[0] : 1'b0;
    endfunction

    // Scoreboard monitor: grants, acks and beat steering checked on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (o_as[k] && !prev_as[k]) begin
                if ((k == 0 && gq0.size() == 0) || (k == 1 && gq1.size() == 0)) begin
                    chk("unexpected_grant", 32'd1, 32'd0);
                end else begin
                    if (k == 0) mon_g = gq0.pop_front();
                    else        mon_g = gq1.pop_front();
                    cur_own[k] = mon_g.owner;
                    chk("grant_addr", {10'd0, o_addr[k]}, {10'd0, mon_g.addr});
                    chk("grant_owner", {31'd0, o_own[k]}, {31'd0, mon_g.owner});
                end
            end
            if (prev_ack && reset_n) chk("mem_as_drop_after_ack", {31'd0, o_as[k]}, 32'd0);
            chk("bus_ack", {30'd0, o_ack[k]}, m_ack ? {30'd0, onehot(cur_own[k])} : 32'd0);
            if (o_bv[k] != 2'b00) begin
                if ((k == 0 && bq0.size() == 0) || (k == 1 && bq1.size() == 0)) begin
                    chk("unexpected_beat", {30'd0, o_bv[k]}, 32'd0);
                end else begin
                    if (k == 0) mon_b = bq0.pop_front();
                    else        mon_b = bq1.pop_front();
                    chk("beat_steer", {30'd0, o_bv[k]}, {30'd0, onehot(mon_b)});
                end
            end
            prev_as[k] = o_as[k];
        end
        prev_ack = m_ack;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_mem_as"}, {31'd0, o_as[k]}, 32'd0);
            chk({tag, "_mem_addr"}, {10'd0, o_addr[k]}, 32'd0);
            chk({tag, "_owner"}, {31'd0, o_own[k]}, 32'd0);
            chk({tag, "_busy"}, {31'd0, o_busy[k]}, 32'd0);
            chk({tag, "_ack"}, {30'd0, o_ack[k]}, 32'd0);
            chk({tag, "_bv"}, {30'd0, o_bv[k]}, 32'd0);
        end
    endtask

    // Raises the requests, predicts both winners and waits for mem_as (expected after one edge).
    task automatic start_req(input logic q0, input logic q1, input logic [21:0] ad0,
                             input logic [21:0] ad1, output logic w0, output logic w1);
        grant_t g;
        int     lat;
        r0 = q0; r1 = q1; a0 = ad0; a1 = ad1;
        w0 = pick_model(0, q0, q1);
        w1 = pick_model(1, q0, q1);
        g.owner = w0; g.addr = w0 ? ad1 : ad0; gq0.push_back(g);
        g.owner = w1; g.addr = w1 ? ad1 : ad0; gq1.push_back(g);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(o_as[0] && o_as[1]) && lat < 8);
        chk("req_to_mem_as_latency", lat, 1);
    endtask

    task automatic drive_beat(input logic w0, input logic w1, input logic [15:0] d);
        m_bv = 1'b1;
        m_din = d;
        bq0.push_back(w0);
        bq1.push_back(w1);
    endtask

    // One full request/accept/burst transaction followed by the end-of-burst idle check.
    task automatic do_round(input logic q0, input logic q1, input logic [21:0] ad0,
                            input logic [21:0] ad1, input logic ack_beat,
                            input int max_gap, input logic [15:0] d0);
        logic w0, w1;
        int   beat;
        start_req(q0, q1, ad0, ad1, w0, w1);
        repeat ($urandom_range(0, max_gap)) tick();
        m_ack = 1'b1;
        beat = 0;
        if (ack_beat) begin
            drive_beat(w0, w1, d0);
            beat = 1;
        end
        tick();
        m_ack = 1'b0; m_bv = 1'b0; r0 = 1'b0; r1 = 1'b0;
        mdl_last[0] = w0;
        mdl_last[1] = w1;
        while (beat < BL) begin
            repeat ($urandom_range(0, max_gap)) tick();
            drive_beat(w0, w1, 16'(d0 * (beat + 1)));
            beat++;
            tick();
            m_bv = 1'b0;
        end
        @(negedge clk);
        chk("busy_after_last_beat_rr", {31'd0, o_busy[0]}, 32'd0);
        chk("busy_after_last_beat_fp", {31'd0, o_busy[1]}, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic w0, w1;
        logic [1:0] q;

        #2;
        check_all_zero("reset");
        tick();
        reset_n = 1'b1;
        tick();
        check_all_zero("post_reset");

        // Lone FILE0 request; beats 0x1111..0x4444 only to FILE0.
        do_round(1'b1, 1'b0, 22'h000100, 22'h2AAAAA, 1'b0, 0, 16'h1111);

        // Beats while idle must be ignored and must not advance the beat count.
        m_bv = 1'b1; m_din = 16'hDEAD;
        repeat (3) tick();
        m_bv = 1'b0;
        chk("idle_beats_busy_rr", {31'd0, o_busy[0]}, 32'd0);
        chk("idle_beats_busy_fp", {31'd0, o_busy[1]}, 32'd0);
        do_round(1'b1, 1'b0, 22'h000200, 22'h000300, 1'b0, 1, 16'h0101);

        // FILE1 withdraws before mem_ack: grant abandoned, fairness history kept.
        start_req(1'b0, 1'b1, 22'h000400, 22'h000500, w0, w1);
        r1 = 1'b0;
        tick();
        chk("drop_mem_as_rr", {31'd0, o_as[0]}, 32'd0);
        chk("drop_mem_as_fp", {31'd0, o_as[1]}, 32'd0);
        chk("drop_busy_rr", {31'd0, o_busy[0]}, 32'd0);
        chk("drop_busy_fp", {31'd0, o_busy[1]}, 32'd0);
        tick();
        do_round(1'b1, 1'b1, 22'h000600, 22'h000700, 1'b0, 0, 16'h0202);

        // Reset arriving mid-burst after beat 2 aborts steering immediately.
        start_req(1'b1, 1'b1, 22'h000800, 22'h000900, w0, w1);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0; r0 = 1'b0; r1 = 1'b0;
        for (int b = 0; b < 3; b++) begin
            drive_beat(w0, w1, 16'(16'h0303 + b));
            tick();
        end
        m_bv = 1'b1; m_din = 16'hBEEF;
        reset_n = 1'b0;
        #1;
        check_all_zero("midburst_reset");
        mdl_last[0] = 1'b1;
        mdl_last[1] = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        m_bv = 1'b0;
        tick();

        // Sustained contention: RR grants 0,1,0,1; fixed grants 0,0,0,0.
        for (int i = 0; i < 4; i++)
            do_round(1'b1, 1'b1, 22'(22'h010000 + i), 22'(22'h020000 + i), 1'b0, 1, 16'h0400);

        // Randomised traffic.
        for (int i = 0; i < 30; i++) begin
            q = 2'($urandom_range(1, 3));
            do_round(q[0], q[1], 22'($urandom), 22'($urandom), 1'($urandom_range(0, 1)),
                     2, 16'($urandom));
        end

        repeat (2) tick();
        chk("grants_left_rr", gq0.size(), 0);
        chk("grants_left_fp", gq1.size(), 0);
        chk("beats_left_rr", bq0.size(), 0);
        chk("beats_left_fp", bq1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
